// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencer of the bubble processor.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StErr    = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsStore,
        ClsLoad,
        ClsJump,
        ClsHalt,
        ClsNop
    } op_class_e;

    localparam logic [5:0] OP_STORE = 6'b010000;
    localparam logic [5:0] OP_LOAD  = 6'b010001;
    localparam logic [5:0] OP_JR    = 6'b100111;
    localparam logic [5:0] OP_JAL   = 6'b101000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] PC_SEL_INC    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JR     = 2'd2;

    function automatic op_class_e decode_class(input logic [5:0] op);
        op_class_e cls;
        case (op[5:4])
            2'b00:   cls = ClsAlu;
            2'b01:   cls = (op == OP_STORE) ? ClsStore : ((op == OP_LOAD) ? ClsLoad : ClsAlu);
            2'b10:   cls = ClsJump;
            default: cls = (op == OP_HALT) ? ClsHalt : ClsNop;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive unacknowledged request cycles and flags the cycle whose
// miss would make the count reach ACK_TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    output logic timeout
);

    localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

    logic [7:0] count_q;

    // Any cycle without a pending miss clears the count, so each new FETCH/MEM starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else if (req && !ack) begin
            count_q <= count_q + 8'd1;
        end else begin
            count_q <= 8'd0;
        end
    end

    assign timeout = req && !ack && (count_q == LAST_WAIT);

endmodule

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer: drives memory handshakes and one-cycle
// datapath write strobes; owns no datapath registers.
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             alu_bit0,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             alu_src_imm,
    output logic             reg_write,
    output logic             wb_sel_mem,
    output logic             link_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    state_e     state_q, state_d;
    op_class_e  cls;
    logic       mem_req, mem_ack, wait_timeout;
    logic [CNT_W-1:0] retired_q;

    assign cls = decode_class(opcode);

    // Derived from the state register alone to keep the timer out of a comb loop.
    assign mem_req = (state_q == StFetch) || (state_q == StMem);
    assign mem_ack = (state_q == StFetch) ? imem_ack :
                     (state_q == StMem)   ? dmem_ack : 1'b0;

    mem_wait_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .req    (mem_req),
        .ack    (mem_ack),
        .timeout(wait_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (pc_write) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        wb_sel_mem  = 1'b0;
        link_write  = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = PC_SEL_INC;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = StDecode;
                end else if (wait_timeout) begin
                    state_d = StErr;
                end
            end
            StDecode: begin
                state_d = (cls == ClsHalt) ? StHalt : StExec;
            end
            StExec: begin
                alu_src_imm = opcode[5] | opcode[4];
                case (cls)
                    ClsJump: begin
                        pc_write   = 1'b1;
                        link_write = (opcode == OP_JAL);
                        if (opcode == OP_JR) pc_sel = PC_SEL_JR;
                        else if (alu_bit0)   pc_sel = PC_SEL_BRANCH;
                        else                 pc_sel = PC_SEL_INC;
                        state_d = StFetch;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsAlu:            state_d = StWb;
                    default: begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end
                endcase
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == ClsStore);
                if (dmem_ack) begin
                    if (cls == ClsStore) begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_timeout) begin
                    state_d = StErr;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                wb_sel_mem = (cls == ClsLoad);
                pc_write   = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = state_q;
        endcase
    end

    assign state   = state_q;
    assign busy    = !((state_q == StIdle) || (state_q == StHalt) || (state_q == StErr));
    assign halted  = (state_q == StHalt);
    assign err     = (state_q == StErr);
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-instruction reference model expands each
// instruction into its expected cycle trace, which is then driven and compared.
module tb_multicycle_controller;

    localparam int unsigned ACK_TO = 15;
    localparam int unsigned CW     = 32;

    logic          clk = 1'b0;
    logic          rst, start, alu_bit0, imem_ack, dmem_ack;
    logic [5:0]    opcode;
    logic          imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, reg_write;
    logic          wb_sel_mem, link_write, pc_write, busy, halted, err;
    logic [1:0]    pc_sel;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    multicycle_controller #(
        .ACK_TIMEOUT(ACK_TO),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .alu_bit0   (alu_bit0),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .ir_load    (ir_load),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .alu_src_imm(alu_src_imm),
        .reg_write  (reg_write),
        .wb_sel_mem (wb_sel_mem),
        .link_write (link_write),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .state      (state),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, iack, dack, ab0;
        logic [5:0] op;
        logic [2:0] st;
        logic       imem_req, ir_load, dmem_req, dmem_we, alu_src_imm;
        logic       reg_write, wb_sel_mem, link_write, pc_write;
        logic [1:0] pc_sel;
    } cyc_t;

    cyc_t          trace[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [CW-1:0] exp_retired;

    // Cycle with random don't-care inputs and all strobes expected low.
    function automatic cyc_t blank(input logic [5:0] op, input logic ab0, input logic [2:0] st);
        cyc_t c;
        c = '{start: 1'($urandom), iack: 1'($urandom), dack: 1'($urandom), ab0: ab0,
              op: op, st: st, pc_sel: 2'd0, default: 1'b0};
        return c;
    endfunction

    function automatic void add_start();
        cyc_t c;
        c = blank(6'd0, 1'b0, 3'd0);
        c.start = 1'b1;
        trace.push_back(c);
    endfunction

    // Expected behaviour of one instruction with idel fetch and ddel data wait cycles.
    function automatic void add_instr(input logic [5:0] op, input logic ab0,
                                      input int idel, input int ddel);
        cyc_t c;
        logic is_store = (op == 6'b010000);
        logic is_load  = (op == 6'b010001);
        logic is_jump  = (op[5:4] == 2'b10);
        logic is_nop   = (op[5:4] == 2'b11) && (op != 6'b111111);
        logic is_alu   = !(is_store || is_load || is_jump || op[5:4] == 2'b11);
        for (int i = 0; i < idel && i < int'(ACK_TO); i++) begin
            c = blank(op, ab0, 3'd1);
            c.iack = 1'b0;
            c.imem_req = 1'b1;
            trace.push_back(c);
        end
        if (idel >= int'(ACK_TO)) begin
            for (int i = 0; i < 3; i++) begin
                c = blank(op, ab0, 3'd7);
                c.iack = 1'b1;
                c.start = 1'b1;
                trace.push_back(c);
            end
            return;
        end
        c = blank(op, ab0, 3'd1);
        c.iack = 1'b1; c.imem_req = 1'b1; c.ir_load = 1'b1;
        trace.push_back(c);
        trace.push_back(blank(op, ab0, 3'd2));
        if (op == 6'b111111) begin
            for (int i = 0; i < 3; i++) begin
                c = blank(op, ab0, 3'd6);
                c.start = 1'b1;
                trace.push_back(c);
            end
            return;
        end
        c = blank(op, ab0, 3'd3);
        c.alu_src_imm = op[5] | op[4];
        if (is_jump) begin
            c.pc_write   = 1'b1;
            c.link_write = (op == 6'b101000);
            c.pc_sel     = (op == 6'b100111) ? 2'd2 : (ab0 ? 2'd1 : 2'd0);
        end else if (is_nop) begin
            c.pc_write = 1'b1;
        end
        trace.push_back(c);
        if (is_store || is_load) begin
            for (int i = 0; i <= ddel; i++) begin
                c = blank(op, ab0, 3'd4);
                c.dack = (i == ddel);
                c.dmem_req = 1'b1;
                c.dmem_we = is_store;
                c.pc_write = is_store && (i == ddel);
                trace.push_back(c);
            end
        end
        if (is_alu || is_load) begin
            c = blank(op, ab0, 3'd5);
            c.reg_write = 1'b1; c.wb_sel_mem = is_load; c.pc_write = 1'b1;
            trace.push_back(c);
        end
    endfunction

    // Drives up to limit queued cycles and compares every output; discards the rest.
    task automatic test_program(input string name, input int limit);
        int n;
        cyc_t c;
        logic [13:0] ev, gv;
        n = (limit < trace.size()) ? limit : trace.size();
        for (int i = 0; i < n; i++) begin
            c = trace[i];
            @(negedge clk);
            start = c.start; imem_ack = c.iack; dmem_ack = c.dack;
            opcode = c.op; alu_bit0 = c.ab0;
            #1;
            ev = {c.imem_req, c.ir_load, c.dmem_req, c.dmem_we, c.alu_src_imm, c.reg_write,
                  c.wb_sel_mem, c.link_write, c.pc_write, c.pc_sel,
                  !(c.st == 3'd0 || c.st == 3'd6 || c.st == 3'd7), c.st == 3'd6, c.st == 3'd7};
            gv = {imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, reg_write,
                  wb_sel_mem, link_write, pc_write, pc_sel, busy, halted, err};
            n_checks++;
            if (state !== c.st)
                $display("FAIL %s state cyc %0d: got %0d want %0d", name, i, state, c.st);
            else n_pass++;
            n_checks++;
            if (gv !== ev)
                $display("FAIL %s outputs cyc %0d: got %b want %b", name, i, gv, ev);
            else n_pass++;
            n_checks++;
            if (retired !== exp_retired)
                $display("FAIL %s retired cyc %0d: got %0d want %0d", name, i, retired,
                         exp_retired);
            else n_pass++;
            if (c.pc_write) exp_retired++;
        end
        trace.delete();
    endtask

    task automatic check_cleared(input string name);
        logic [13:0] gv;
        gv = {imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, reg_write,
              wb_sel_mem, link_write, pc_write, pc_sel, busy, halted, err};
        n_checks++;
        if (state !== 3'd0) $display("FAIL %s state: got %0d want 0", name, state);
        else n_pass++;
        n_checks++;
        if (gv !== 14'd0) $display("FAIL %s outputs: got %b want 0", name, gv);
        else n_pass++;
        n_checks++;
        if (retired !== '0) $display("FAIL %s retired: got %0d want 0", name, retired);
        else n_pass++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; rst = 1'b0;
        exp_retired = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        opcode = 6'b000001; alu_bit0 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_cleared("reset");
        release_reset();
    endtask

    task automatic test_alu();
        add_start();
        add_instr(6'b000001, 1'b0, 0, 0);
        test_program("alu", 1000);
    endtask

    task automatic test_load();
        add_instr(6'b010001, 1'b0, 0, 3);
        add_instr(6'b010000, 1'b1, 1, 2);
        test_program("load_store", 1000);
    endtask

    task automatic test_branches();
        add_instr(6'b100000, 1'b1, 0, 0);
        add_instr(6'b100000, 1'b0, 0, 0);
        add_instr(6'b101000, 1'b1, 0, 0);
        add_instr(6'b100111, 1'b0, 0, 0);
        add_instr(6'b110101, 1'b1, 0, 0);
        test_program("branches", 1000);
    endtask

    // Ack arriving in the last allowed wait cycle must win over the timeout.
    task automatic test_ack_boundary();
        add_instr(6'b010001, 1'b0, int'(ACK_TO) - 1, int'(ACK_TO) - 1);
        add_instr(6'b010000, 1'b0, int'(ACK_TO) - 1, int'(ACK_TO) - 1);
        test_program("ack_boundary", 1000);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            add_instr(6'($urandom_range(0, 62)), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3));
        end
        test_program("back_to_back", 1000);
    endtask

    task automatic test_reset_mid_mem();
        add_instr(6'b010000, 1'b0, 1, 6);
        test_program("mid_mem", 5);
        #2 rst = 1'b1;
        #1;
        check_cleared("mid_mem_reset");
        release_reset();
    endtask

    task automatic test_timeout();
        add_start();
        add_instr(6'b000010, 1'b0, int'(ACK_TO) + 3, 0);
        test_program("timeout", 1000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_cleared("timeout_reset");
        release_reset();
    endtask

    task automatic test_halt();
        add_start();
        add_instr(6'b011010, 1'b0, 0, 0);
        add_instr(6'b111111, 1'b0, 2, 0);
        test_program("halt", 1000);
    endtask

    initial begin
        exp_retired = '0;
        test_reset();
        test_alu();
        test_load();
        test_branches();
        test_ack_boundary();
        test_back_to_back();
        test_reset_mid_mem();
        test_timeout();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
